// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter
//   Three-way round-robin arbiter and sequencer for the shared memory/IO bus.
//   Requester 0 = CPU, 1 = VGA sprite updater, 2 = keyboard DMA.
//   The winner's address, write data and write enable are registered onto the
//   bus for ACC_CYC cycles. Read data is captured on the last bus cycle, and
//   completion is signalled with a one-cycle ack. A locked requester may keep
//   the bus for up to LOCK_MAX back-to-back transactions.
//
// Handshake: req is a level. addr/wdata/we must be valid in the cycle that req
//   is sampled (IDLE, or DONE for a locked regrant). gnt stays high for the
//   whole access window. ack pulses for one cycle when the access completes,
//   and rdata is valid with that pulse. Dropping req after grant does not
//   abort the access.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req, we, lock [2:0]   per-requester request, write enable, lock
//   addr, wdata [95:0]    per-requester address / write data, slice [32*i+31:32*i]
//   gnt, ack [2:0]        one-hot grant (access window) / completion pulse
//   rdata [31:0]          captured read data, held until the next capture
//   bus_addr, bus_wdata, bus_mem_w   registered bus drive
//   bus_rdata [31:0]      read data returned by the bus decoder
//   state_dbg [1:0]       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mio_bus_arbiter #(
  parameter int ACC_CYC  = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [2:0]  lock,
  input  logic [95:0] addr,
  input  logic [95:0] wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [31:0] rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_mem_w,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST  = 4'(ACC_CYC - 1);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [3:0] cnt;
  logic [3:0] lock_cnt;

  logic [1:0] arb_idx;
  logic       arb_hit;
  logic [1:0] cand;
  logic [1:0] ptr_next;

  function automatic logic [31:0] slice32(input logic [95:0] v, input logic [1:0] i);
    case (i)
      2'd1:    return v[63:32];
      2'd2:    return v[95:64];
      default: return v[31:0];
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'(3'b001 << i);
  endfunction

  // Search ptr, ptr+1, ptr+2 (mod 3). Walking the offsets from far to near lets
  // the nearest requesting index overwrite the others.
  always_comb begin
    arb_idx = ptr;
    arb_hit = 1'b0;
    cand    = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = 2'((int'(ptr) + i) % 3);
      if (req[cand]) begin
        arb_idx = cand;
        arb_hit = 1'b1;
      end
    end
  end

  assign ptr_next  = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      winner    <= 2'd0;
      cnt       <= 4'd0;
      lock_cnt  <= 4'd0;
      gnt       <= 3'b000;
      ack       <= 3'b000;
      rdata     <= 32'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_mem_w <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            winner    <= arb_idx;
            bus_addr  <= slice32(addr, arb_idx);
            bus_wdata <= slice32(wdata, arb_idx);
            bus_mem_w <= we[arb_idx];
            gnt       <= onehot(arb_idx);
            cnt       <= 4'd0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            // Captured for writes as well; the requester ignores it then.
            rdata     <= bus_rdata;
            gnt       <= 3'b000;
            bus_mem_w <= 1'b0;
            ack       <= onehot(winner);
            state     <= DONE;
          end
        end
        DONE: begin
          ack <= 3'b000;
          ptr <= ptr_next;
          if (lock[winner] && req[winner] && (lock_cnt < LOCK_LAST)) begin
            // Locked regrant bypasses arbitration entirely.
            bus_addr  <= slice32(addr, winner);
            bus_wdata <= slice32(wdata, winner);
            bus_mem_w <= we[winner];
            gnt       <= onehot(winner);
            cnt       <= 4'd0;
            lock_cnt  <= lock_cnt + 4'd1;
            state     <= BUSY;
          end else begin
            lock_cnt <= 4'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Testbench for mio_bus_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-timeline reference model.
module tb_mio_bus_arbiter;

  localparam int ACC  = 2;
  localparam int LMAX = 4;
  localparam int RING = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, lock;
  logic [95:0] addr, wdata;
  logic [2:0]  gnt, ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic        bus_mem_w;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.ACC_CYC(ACC), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mem_w(bus_mem_w),
    .bus_rdata(bus_rdata), .state_dbg(state_dbg)
  );

  // Bus decoder stand-in: combinational read data from address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign bus_rdata = rd_fn(bus_addr);

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];
  int ack_cyc_q[$];
  int ack_id_q[$];

  // Reference model: each transaction is laid out on a timeline of future
  // cycles when it is decided.
  int          m_next = 0;
  bit          m_lockchk = 1'b0;
  int          m_w = 0;
  int          m_ptr = 0;
  int          m_lock_cnt = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [2:0]  e_gnt[RING];
  logic [2:0]  e_ack[RING];
  logic        e_mw[RING];
  logic        e_rv[RING];
  logic [31:0] e_rd[RING];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic ring_clear();
    for (int i = 0; i < RING; i++) begin
      e_gnt[i] = '0; e_ack[i] = '0; e_mw[i] = 1'b0; e_rv[i] = 1'b0; e_rd[i] = '0;
    end
  endtask

  task automatic model_start(input int t, input int w);
    m_w     = w;
    m_addr  = addr[32*w +: 32];
    m_wdata = wdata[32*w +: 32];
    for (int k = 1; k <= ACC; k++) begin
      e_gnt[(t + k) % RING] = 3'(1 << w);
      e_mw[(t + k) % RING]  = we[w];
    end
    e_ack[(t + ACC + 1) % RING] = 3'(1 << w);
    e_rv[(t + ACC + 1) % RING]  = 1'b1;
    e_rd[(t + ACC + 1) % RING]  = rd_fn(m_addr);
    m_next    = t + ACC + 1;
    m_lockchk = 1'b1;
  endtask

  // Consumes the inputs sampled at the end of cycle t.
  task automatic model_step(input int t);
    bit found;
    int c;
    if (rst) begin
      ring_clear();
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_ptr = 0; m_lock_cnt = 0; m_next = t + 1; m_lockchk = 1'b0;
    end else if (t == m_next) begin
      if (m_lockchk) begin
        m_ptr = (m_w + 1) % 3;
        if (lock[m_w] && req[m_w] && m_lock_cnt < LMAX - 1) begin
          m_lock_cnt++;
          model_start(t, m_w);
        end else begin
          m_lock_cnt = 0;
          m_lockchk  = 1'b0;
          m_next     = t + 1;
        end
      end else begin
        found = 1'b0;
        for (int off = 0; off < 3; off++) begin
          c = (m_ptr + off) % 3;
          if (!found && req[c]) begin
            found = 1'b1;
            model_start(t, c);
          end
        end
        if (!found) m_next = t + 1;
      end
    end
  endtask

  task automatic compare_all(input int c);
    int i;
    i = c % RING;
    if (e_rv[i]) m_rdata = e_rd[i];
    check("gnt", gnt, e_gnt[i]);
    check("ack", ack, e_ack[i]);
    check("bus_mem_w", bus_mem_w, e_mw[i]);
    check("bus_addr", bus_addr, m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("rdata", rdata, m_rdata);
    e_gnt[i] = '0; e_ack[i] = '0; e_mw[i] = 1'b0; e_rv[i] = 1'b0;
  endtask

  // One clock: model consumes this cycle's inputs, outputs checked 1 time unit
  // after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(cyc);
    cyc++;
    #1;
    compare_all(cyc);
    if (ack != 3'b000) begin
      ack_cyc_q.push_back(cyc);
      ack_id_q.push_back(ack[0] ? 0 : (ack[1] ? 1 : 2));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    req = r; we = w; lock = l;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    set_in(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    rst = 1'b0;
    ack_cyc_q.delete();
    ack_id_q.delete();
    exp_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_log(input string tag, input int gap0, input int gap_last, input int n_equal);
    check({tag, "_count"}, ack_id_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ack_id_q.size(); k++) begin
      check({tag, "_order"}, ack_id_q[k], exp_q[k]);
      if (k > 0) check({tag, "_gap"}, ack_cyc_q[k] - ack_cyc_q[k-1], (k <= n_equal) ? gap0 : gap_last);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(3'b000, 3'b000, 3'b000);
    addr = '0; wdata = '0;

    // Reset state
    reset_dut();
    check("rst_state", state_dbg, 0);
    check("rst_gnt", gnt, 0);
    check("rst_rdata", rdata, 0);

    // Single CPU read
    addr[31:0] = 32'h0000_0010;
    set_in(3'b001, 3'b000, 3'b000);
    tick();
    set_in(3'b000, 3'b000, 3'b000);
    check("rd_gnt1", gnt, 3'b001);
    check("rd_addr", bus_addr, 32'h0000_0010);
    check("rd_mw", bus_mem_w, 0);
    tick();
    check("rd_gnt2", gnt, 3'b001);
    tick();
    check("rd_ack", ack, 3'b001);
    check("rd_data", rdata, 32'hDEAD_BEEF);
    run(2);

    // Single VGA write
    reset_dut();
    addr[63:32] = 32'hC000_0040;
    wdata[63:32] = 32'h0000_00FF;
    set_in(3'b010, 3'b010, 3'b000);
    tick();
    set_in(3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 2; k++) begin
      check("wr_mw", bus_mem_w, 1);
      check("wr_addr", bus_addr, 32'hC000_0040);
      check("wr_data", bus_wdata, 32'h0000_00FF);
      tick();
    end
    check("wr_ack", ack, 3'b010);
    check("wr_mw_done", bus_mem_w, 0);
    run(2);

    // All three held high, unlocked: 0,1,2,0,1,2 with ACC+2 spacing
    reset_dut();
    addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    set_in(3'b111, 3'b000, 3'b000);
    run(6 * (ACC + 2) + 2);
    for (int k = 0; k < 6; k++) exp_q.push_back(2'(k % 3));
    check_log("rr", ACC + 2, ACC + 2, 5);

    // CPU locked: LMAX back-to-back, then requester 1
    reset_dut();
    set_in(3'b111, 3'b000, 3'b001);
    run(LMAX * (ACC + 1) + ACC + 4);
    for (int k = 0; k < LMAX; k++) exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    check_log("lock", ACC + 1, ACC + 2, LMAX - 1);
    set_in(3'b000, 3'b000, 3'b000);
    run(ACC + 3);

    // Reset in the second BUSY cycle of a CPU write
    reset_dut();
    addr[31:0] = 32'h0000_0800;
    set_in(3'b001, 3'b001, 3'b000);
    tick();
    set_in(3'b000, 3'b000, 3'b000);
    tick();
    check("rb_mw_busy", bus_mem_w, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb_mw", bus_mem_w, 0);
    check("rb_gnt", gnt, 0);
    check("rb_ack", ack, 0);
    check("rb_addr", bus_addr, 0);
    check("rb_state", state_dbg, 0);
    ack_id_q.delete();
    run(3);
    check("rb_no_ack", ack_id_q.size(), 0);
    set_in(3'b011, 3'b000, 3'b000);
    tick();
    check("rb_rearb", gnt, 3'b001);
    set_in(3'b000, 3'b000, 3'b000);
    run(ACC + 2);

    // Requester 2 withdraws after grant
    reset_dut();
    addr[95:64] = 32'h0000_4444;
    set_in(3'b100, 3'b000, 3'b000);
    tick();
    set_in(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    check("drop_ack", ack, 3'b100);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("drop_no_gnt", gnt, 0);
    end

    // Random traffic
    reset_dut();
    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      req   = 3'($urandom_range(0, 7));
      we    = 3'($urandom_range(0, 7));
      lock  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      addr  = {$urandom(), $urandom(), $urandom()};
      wdata = {$urandom(), $urandom(), $urandom()};
      tick();
    end
    rst = 1'b0;
    set_in(3'b000, 3'b000, 3'b000);
    run(ACC + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
